reg_init_seq: RTL and testbench
===============================

REG_INIT_SEQ -- requirements
Module: reg_init_seq

Interface
REQ-001 SHALL have parameter N_INIT, default 2, number of init table entries (1-64).
REQ-002 SHALL have parameter AUTO_START, default 1, start sequence automatically on the first cycle after reset release.
REQ-003 SHALL have parameter POLL_MAX, default 1024, maximum reads per POLL entry before error.
REQ-004 SHALL have parameter APB_TIMEOUT, default 256, maximum cycles waiting on i_pready per access.
REQ-005 SHALL have ports i_apb_clk input 1 (sole clock) and i_apb_rst input 1 (reset); one clock; reset is synchronous and active-high.
REQ-006 SHALL have port i_init_table input N_INIT*66: entry k at bits [66k+65:66k] = {op[1:0], addr[31:0], data[31:0]}; static while o_busy=1.
REQ-007 SHALL have port i_start input 1: single-cycle pulse that (re)starts the sequence.
REQ-008 SHALL have APB master ports o_psel, o_penable, o_pwrite (outputs, 1 each), o_paddr, o_pwdata (outputs, 32 each), i_pready, i_pslverr (inputs, 1 each) and i_prdata (input, 32).
REQ-009 SHALL have status outputs o_busy 1, o_done 1 (sticky), o_error 1 (sticky) and o_err_idx 6 (index of failing entry).

Function
REQ-010 SHALL decode op: 0 WRITE (APB write data to addr), 1 DELAY (idle data[31:0] cycles, addr ignored), 2 POLL (APB read addr until i_prdata==data), 3 END (terminate early).
REQ-011 SHALL implement states IDLE, FETCH, SETUP, ACCESS, WAIT, DONE, ERR.
REQ-012 IDLE -> FETCH with index 0 on i_start, or on first post-reset cycle if AUTO_START=1; entering FETCH clears o_done, o_error, o_err_idx.
REQ-013 FETCH: index==N_INIT or op==END -> DONE; op==DELAY -> WAIT (counter loaded with data); otherwise -> SETUP.
REQ-014 SETUP drives o_psel=1, o_penable=0, o_paddr, o_pwrite (1 for WRITE, 0 for POLL), o_pwdata (data for WRITE, 0 for POLL) for exactly one cycle, then -> ACCESS.
REQ-015 ACCESS holds psel=1, penable=1 and all address/control/data stable until i_pready=1; the transfer completes on that cycle.
REQ-016 On completion with i_pslverr=1 -> ERR; else WRITE -> index+1, FETCH; POLL match -> index+1, FETCH; POLL mismatch -> poll counter+1, SETUP.
REQ-017 POLL counter resets per entry; mismatch on read number POLL_MAX -> ERR.
REQ-018 ACCESS lasting APB_TIMEOUT cycles without i_pready -> ERR; psel/penable deassert next cycle.
REQ-019 WAIT decrements counter each cycle, -> index+1, FETCH when counter reaches 0; DELAY with data=0 spends exactly one WAIT cycle.
REQ-020 DONE sets o_done=1, ERR sets o_error=1 and o_err_idx=current index; both then -> IDLE in the next cycle.
REQ-021 o_busy SHALL be 1 in every state except IDLE.
REQ-022 i_start while o_busy=1 SHALL be ignored (no abort, no queue).
REQ-023 o_psel, o_penable SHALL be 0 outside SETUP/ACCESS; back-to-back accesses separated by at least one FETCH cycle.
REQ-024 Zero-wait write entry SHALL take 3 cycles (FETCH, SETUP, ACCESS).

Reset
REQ-025 While i_apb_rst=1: state IDLE, index 0, all counters 0, o_psel=o_penable=o_pwrite=0, o_paddr=o_pwdata=0, o_busy=o_done=o_error=0, o_err_idx=0.
REQ-026 Reset asserted mid-access SHALL drop psel/penable on the next clock edge with no completion recorded; no restart until reset releases (then AUTO_START rule applies).

Verification
REQ-027 Table {W 0x0200_0024<=0x12B7, W 0x0201_0024<=0x12B7}, AUTO_START=1, pready tied 1 -> two APB writes in order, 3 cycles each, o_done=1 after 7 cycles post-reset, o_error=0.
REQ-028 POLL 0x0000_0010 ==0x1, slave returns 0x0 three times then 0x1 -> 4 reads, then next entry; POLL_MAX=3 with same stimulus -> o_error=1, o_err_idx=entry index.
REQ-029 DELAY data=100 between two writes -> second write psel rises exactly 102 cycles after first write completes.
REQ-030 i_pslverr=1 on entry 1 of 3 -> o_error=1, o_err_idx=1, entry 2 never issued; subsequent i_start reruns from entry 0 and clears o_error.
REQ-031 i_pready held 0 -> psel drops after APB_TIMEOUT=256 ACCESS cycles, o_error=1; i_start pulse during busy has no effect.
REQ-032 Reset asserted during ACCESS of entry 1 -> psel=0 next cycle, all status 0; after release the sequence restarts at entry 0.

Source files
------------

// File: rtl/reg_init_seq.sv
// Register init sequencer: walks a static table of WRITE/DELAY/POLL/END entries
// and replays them as APB master transfers, reporting done/error status.
module reg_init_seq #(
    parameter int N_INIT      = 2,
    parameter int AUTO_START  = 1,
    parameter int POLL_MAX    = 1024,
    parameter int APB_TIMEOUT = 256
) (
    input  logic                 i_apb_clk,
    input  logic                 i_apb_rst,
    input  logic [N_INIT*66-1:0] i_init_table,
    input  logic                 i_start,
    output logic                 o_psel,
    output logic                 o_penable,
    output logic                 o_pwrite,
    output logic [31:0]          o_paddr,
    output logic [31:0]          o_pwdata,
    input  logic                 i_pready,
    input  logic                 i_pslverr,
    input  logic [31:0]          i_prdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [5:0]           o_err_idx
);
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_DELAY = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;
    localparam logic [1:0] OP_END   = 2'd3;
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int TW = $clog2(APB_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SETUP, S_ACCESS, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t        r_state, w_next;
    logic [6:0]    r_idx;
    logic [31:0]   r_dly;
    logic [PW-1:0] r_poll;
    logic [TW-1:0] r_tmo;
    logic          r_auto;
    logic          r_done;
    logic          r_error;
    logic [5:0]    r_err_idx;

    logic [65:0]   w_entry;
    logic [1:0]    w_op;
    logic [31:0]   w_addr;
    logic [31:0]   w_data;
    logic          w_apb;
    logic          w_xfer;
    logic          w_match;
    logic          w_poll_last;
    logic          w_tmo_last;
    logic          w_adv;

    // Index N_INIT selects nothing; FETCH treats it as end of table.
    always_comb begin
        w_entry = '0;
        for (int k = 0; k < N_INIT; k++)
            if (r_idx == 7'(k)) w_entry = i_init_table[k*66 +: 66];
    end

    assign w_op        = w_entry[65:64];
    assign w_addr      = w_entry[63:32];
    assign w_data      = w_entry[31:0];
    assign w_apb       = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign w_xfer      = (r_state == S_ACCESS) && i_pready;
    assign w_match     = (i_prdata == w_data);
    assign w_poll_last = (r_poll == PW'(POLL_MAX - 1));
    assign w_tmo_last  = (r_tmo == TW'(APB_TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        w_adv  = 1'b0;
        case (r_state)
            S_IDLE:   if (i_start || r_auto) w_next = S_FETCH;
            S_FETCH: begin
                if (r_idx == 7'(N_INIT) || w_op == OP_END) w_next = S_DONE;
                else if (w_op == OP_DELAY)                 w_next = S_WAIT;
                else                                       w_next = S_SETUP;
            end
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: begin
                if (w_xfer) begin
                    if (i_pslverr) w_next = S_ERR;
                    else if (w_op == OP_WRITE || w_match) begin
                        w_next = S_FETCH;
                        w_adv  = 1'b1;
                    end
                    else if (w_poll_last) w_next = S_ERR;
                    else                  w_next = S_SETUP;
                end else if (w_tmo_last) begin
                    w_next = S_ERR;
                end
            end
            // A loaded count of 0 or 1 both leave after a single WAIT cycle.
            S_WAIT: if (r_dly <= 32'd1) begin
                w_next = S_FETCH;
                w_adv  = 1'b1;
            end
            S_DONE, S_ERR: w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_apb_clk) begin
        if (i_apb_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_dly     <= '0;
            r_poll    <= '0;
            r_tmo     <= '0;
            r_auto    <= (AUTO_START != 0);
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
        end else begin
            r_state <= w_next;
            r_auto  <= 1'b0;
            if (r_state == S_IDLE && w_next == S_FETCH) begin
                r_idx     <= '0;
                r_done    <= 1'b0;
                r_error   <= 1'b0;
                r_err_idx <= '0;
            end
            if (w_adv) r_idx <= r_idx + 7'd1;
            if (r_state == S_FETCH) begin
                r_poll <= '0;
                r_dly  <= w_data;
            end
            if (r_state == S_WAIT) r_dly <= r_dly - 32'd1;
            if (r_state == S_SETUP)       r_tmo <= '0;
            else if (r_state == S_ACCESS) r_tmo <= r_tmo + TW'(1);
            if (w_xfer && !i_pslverr && w_op == OP_POLL && !w_match)
                r_poll <= r_poll + PW'(1);
            if (w_next == S_DONE) r_done <= 1'b1;
            if (w_next == S_ERR) begin
                r_error   <= 1'b1;
                r_err_idx <= r_idx[5:0];
            end
        end
    end

    assign o_psel    = w_apb;
    assign o_penable = (r_state == S_ACCESS);
    assign o_pwrite  = w_apb && (w_op == OP_WRITE);
    assign o_paddr   = w_apb ? w_addr : 32'd0;
    assign o_pwdata  = (w_apb && w_op == OP_WRITE) ? w_data : 32'd0;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_error   = r_error;
    assign o_err_idx = r_err_idx;
endmodule

// File: tb/tb_reg_init_seq.sv
// Directed bench for reg_init_seq: three instances cover auto-start, the
// main sequencing/error paths, and a small POLL_MAX configuration.
`timescale 1ns/1ps
module tb_reg_init_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic logic [65:0] ent(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        return {op, a, d};
    endfunction

    // u0: default parameters, slave always ready
    logic [131:0] tab0;
    logic         o0_psel, o0_penable, o0_pwrite, o0_busy, o0_done, o0_error;
    logic [31:0]  o0_paddr, o0_pwdata;
    logic [5:0]   o0_eidx;

    // u1: main instance; u2: POLL_MAX=3
    logic [263:0] tab1;
    logic [131:0] tab2;
    logic         start1 = 1'b0, start2 = 1'b0;
    logic         p1_psel, p1_penable, p1_pwrite, p1_busy, p1_done, p1_error;
    logic [31:0]  p1_paddr, p1_pwdata;
    logic [5:0]   p1_eidx;
    logic         p2_psel, p2_penable, p2_pwrite, p2_busy, p2_done, p2_error;
    logic [31:0]  p2_paddr, p2_pwdata;
    logic [5:0]   p2_eidx;

    logic         pready = 1'b0, pslverr = 1'b0;
    logic [31:0]  prdata = 32'd0;

    reg_init_seq u0 (
        .i_apb_clk(clk), .i_apb_rst(rst), .i_init_table(tab0), .i_start(1'b0),
        .o_psel(o0_psel), .o_penable(o0_penable), .o_pwrite(o0_pwrite),
        .o_paddr(o0_paddr), .o_pwdata(o0_pwdata),
        .i_pready(1'b1), .i_pslverr(1'b0), .i_prdata(32'd0),
        .o_busy(o0_busy), .o_done(o0_done), .o_error(o0_error), .o_err_idx(o0_eidx)
    );

    reg_init_seq #(.N_INIT(4), .AUTO_START(1), .POLL_MAX(1024), .APB_TIMEOUT(256)) u1 (
        .i_apb_clk(clk), .i_apb_rst(rst), .i_init_table(tab1), .i_start(start1),
        .o_psel(p1_psel), .o_penable(p1_penable), .o_pwrite(p1_pwrite),
        .o_paddr(p1_paddr), .o_pwdata(p1_pwdata),
        .i_pready(pready), .i_pslverr(pslverr), .i_prdata(prdata),
        .o_busy(p1_busy), .o_done(p1_done), .o_error(p1_error), .o_err_idx(p1_eidx)
    );

    reg_init_seq #(.N_INIT(2), .AUTO_START(0), .POLL_MAX(3), .APB_TIMEOUT(256)) u2 (
        .i_apb_clk(clk), .i_apb_rst(rst), .i_init_table(tab2), .i_start(start2),
        .o_psel(p2_psel), .o_penable(p2_penable), .o_pwrite(p2_pwrite),
        .o_paddr(p2_paddr), .o_pwdata(p2_pwdata),
        .i_pready(pready), .i_pslverr(pslverr), .i_prdata(prdata),
        .o_busy(p2_busy), .o_done(p2_done), .o_error(p2_error), .o_err_idx(p2_eidx)
    );

    logic        sel = 1'b0;
    logic        m_psel, m_penable, m_pwrite, m_busy;
    logic [31:0] m_paddr, m_pwdata;
    assign m_psel    = sel ? p2_psel    : p1_psel;
    assign m_penable = sel ? p2_penable : p1_penable;
    assign m_pwrite  = sel ? p2_pwrite  : p1_pwrite;
    assign m_paddr   = sel ? p2_paddr   : p1_paddr;
    assign m_pwdata  = sel ? p2_pwdata  : p1_pwdata;
    assign m_busy    = sel ? p2_busy    : p1_busy;

    // slave model and transfer log
    logic        ready_en   = 1'b1;
    logic [31:0] err_addr   = 32'hFFFF_FFFF;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    logic        prev_psel  = 1'b0;
    int          nx, nr, nrd, nacc;
    logic [31:0] xa [16];
    logic [31:0] xd [16];
    logic        xw [16];
    int          xc [16];
    int          rc [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        nx = 0; nr = 0; nrd = 0; nacc = 0; prev_psel = 1'b0;
    endtask

    // One cycle: sample at negedge, answer the current ACCESS (if any) before the next edge.
    task automatic step();
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'd0;
        if (m_psel && !prev_psel) begin
            if (nr < 16) rc[nr] = cyc;
            nr++;
        end
        prev_psel = m_psel;
        if (m_psel && m_penable) begin
            nacc++;
            pready  = ready_en && (m_paddr != stall_addr);
            pslverr = (m_paddr == err_addr);
            prdata  = (nrd >= 3) ? 32'h1 : 32'h0;
            if (pready) begin
                if (nx < 16) begin
                    xa[nx] = m_paddr; xd[nx] = m_pwdata; xw[nx] = m_pwrite; xc[nx] = cyc;
                end
                nx++;
                if (!m_pwrite) nrd++;
            end
        end
    endtask

    task automatic run(input int budget);
        int i = 0;
        step();
        while (m_busy && i < budget) begin
            step();
            i++;
        end
        chk("run_bound", 32'(m_busy), 32'd0);
    endtask

    task automatic pulse1();
        start1 = 1'b1; step(); start1 = 1'b0;
    endtask

    int c0, b0, d0, n0;
    logic [31:0] a0 [2];
    logic [31:0] dd0 [2];
    int cc0 [2];
    bit found;

    initial begin
        tab0 = {ent(2'd0, 32'h0201_0024, 32'h12B7), ent(2'd0, 32'h0200_0024, 32'h12B7)};
        tab1 = {4{ent(2'd3, 32'd0, 32'd0)}};
        tab2 = {ent(2'd2, 32'h10, 32'h1), ent(2'd0, 32'h70, 32'h5)};
        clear_log();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(o0_busy), 32'd0);
        chk("rst_done",   32'(o0_done), 32'd0);
        chk("rst_error",  32'(o0_error), 32'd0);
        chk("rst_psel",   32'(o0_psel), 32'd0);
        chk("rst_pen",    32'(o0_penable), 32'd0);
        chk("rst_pwrite", 32'(o0_pwrite), 32'd0);
        chk("rst_paddr",  o0_paddr, 32'd0);
        chk("rst_pwdata", o0_pwdata, 32'd0);
        chk("rst_eidx",   32'(o0_eidx), 32'd0);
        chk("rst_busy1",  32'(p1_busy), 32'd0);

        // auto start, two zero-wait writes
        rst = 1'b0; c0 = cyc; b0 = -1; d0 = -1; n0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o0_busy && b0 < 0) b0 = cyc;
            if (o0_done && d0 < 0) d0 = cyc;
            if (o0_psel && o0_penable) begin
                if (n0 < 2) begin a0[n0] = o0_paddr; dd0[n0] = o0_pwdata; cc0[n0] = cyc; end
                n0++;
            end
        end
        chk("auto_busy_cyc", 32'(b0 - c0), 32'd1);
        chk("auto_done_cyc", 32'(d0 - b0), 32'd7);
        chk("auto_nwr",      32'(n0), 32'd2);
        chk("auto_addr0",    a0[0], 32'h0200_0024);
        chk("auto_addr1",    a0[1], 32'h0201_0024);
        chk("auto_data0",    dd0[0], 32'h12B7);
        chk("auto_spacing",  32'(cc0[1] - cc0[0]), 32'd3);
        chk("auto_error",    32'(o0_error), 32'd0);
        chk("auto_done",     32'(o0_done), 32'd1);

        // poll: three mismatches then a match, then the next write
        tab1 = {ent(2'd3, 32'd0, 32'd0), ent(2'd3, 32'd0, 32'd0),
                ent(2'd0, 32'h20, 32'hAB), ent(2'd2, 32'h10, 32'h1)};
        clear_log(); pulse1(); run(100);
        chk("poll_reads", 32'(nrd), 32'd4);
        chk("poll_nx",    32'(nx), 32'd5);
        chk("poll_addr",  xa[0], 32'h10);
        chk("poll_rd",    32'(xw[0]), 32'd0);
        chk("poll_wdata", xd[0], 32'd0);
        chk("poll_next",  xa[4], 32'h20);
        chk("poll_nextd", xd[4], 32'hAB);
        chk("poll_done",  32'(p1_done), 32'd1);
        chk("poll_err",   32'(p1_error), 32'd0);

        // delay of 100 between two writes
        tab1 = {ent(2'd3, 32'd0, 32'd0), ent(2'd0, 32'h34, 32'h2),
                ent(2'd1, 32'hDEAD, 32'd100), ent(2'd0, 32'h30, 32'h1)};
        clear_log(); pulse1(); run(300);
        chk("dly_nx",   32'(nx), 32'd2);
        chk("dly_addr", xa[1], 32'h34);
        // completion edge closes the ACCESS cycle; psel rises on the edge opening SETUP
        chk("dly_gap",  32'(rc[1] - (xc[0] + 1)), 32'd102);
        chk("dly_done", 32'(p1_done), 32'd1);

        // slave error on entry 1 of 3
        tab1 = {ent(2'd3, 32'd0, 32'd0), ent(2'd0, 32'h48, 32'h3),
                ent(2'd0, 32'h44, 32'h2), ent(2'd0, 32'h40, 32'h1)};
        err_addr = 32'h44;
        clear_log(); pulse1(); run(100);
        chk("slv_error", 32'(p1_error), 32'd1);
        chk("slv_eidx",  32'(p1_eidx), 32'd1);
        chk("slv_done",  32'(p1_done), 32'd0);
        chk("slv_nsel",  32'(nr), 32'd2);
        chk("slv_nx",    32'(nx), 32'd2);
        err_addr = 32'hFFFF_FFFF;
        clear_log(); pulse1();
        chk("rerun_clr", 32'(p1_error), 32'd0);
        run(100);
        chk("rerun_done", 32'(p1_done), 32'd1);
        chk("rerun_nx",   32'(nx), 32'd3);
        chk("rerun_a0",   xa[0], 32'h40);
        chk("rerun_a2",   xa[2], 32'h48);

        // pready stuck low; extra start while busy
        tab1 = {ent(2'd3, 32'd0, 32'd0), ent(2'd3, 32'd0, 32'd0),
                ent(2'd3, 32'd0, 32'd0), ent(2'd0, 32'h50, 32'h7)};
        ready_en = 1'b0;
        clear_log(); pulse1();
        repeat (10) step();
        pulse1();
        run(400);
        chk("tmo_acc",   32'(nacc), 32'd256);
        chk("tmo_error", 32'(p1_error), 32'd1);
        chk("tmo_eidx",  32'(p1_eidx), 32'd0);
        chk("tmo_nsel",  32'(nr), 32'd1);
        chk("tmo_done",  32'(p1_done), 32'd0);
        repeat (5) step();
        chk("tmo_idle",  32'(p1_busy), 32'd0);
        ready_en = 1'b1;

        // reset during ACCESS of entry 1
        tab1 = {ent(2'd3, 32'd0, 32'd0), ent(2'd3, 32'd0, 32'd0),
                ent(2'd0, 32'h64, 32'h9), ent(2'd0, 32'h60, 32'h8)};
        stall_addr = 32'h64;
        clear_log(); pulse1();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (m_psel && m_penable && m_paddr == 32'h64) found = 1'b1;
        end
        chk("mid_found", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_psel",  32'(p1_psel), 32'd0);
        chk("mid_pen",   32'(p1_penable), 32'd0);
        chk("mid_paddr", p1_paddr, 32'd0);
        chk("mid_busy",  32'(p1_busy), 32'd0);
        chk("mid_done",  32'(p1_done), 32'd0);
        chk("mid_error", 32'(p1_error), 32'd0);
        stall_addr = 32'hFFFF_FFFF;
        step(); step();
        chk("mid_hold",  32'(p1_busy), 32'd0);
        clear_log();
        rst = 1'b0;
        run(100);
        chk("mid_nx",   32'(nx), 32'd2);
        chk("mid_a0",   xa[0], 32'h60);
        chk("mid_a1",   xa[1], 32'h64);
        chk("mid_rdone", 32'(p1_done), 32'd1);

        // POLL_MAX=3: three mismatching reads on entry 1 -> error
        sel = 1'b1;
        clear_log();
        start2 = 1'b1; step(); start2 = 1'b0;
        run(100);
        chk("pmax_error", 32'(p2_error), 32'd1);
        chk("pmax_eidx",  32'(p2_eidx), 32'd1);
        chk("pmax_done",  32'(p2_done), 32'd0);
        chk("pmax_reads", 32'(nrd), 32'd3);
        chk("pmax_wr",    xa[0], 32'h70);
        chk("pmax_nx",    32'(nx), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
